sobel_window_gen: RTL and testbench
===================================

Name: sobel_window_gen

Overview:
Streaming 3x3 neighbourhood generator for the Sobel path, parametrised in pixel width and frame geometry. Accepts raster-order grey pixels, one per strobe, and buffers the two previous rows in line buffers. Emits one full 3x3 window per accepted pixel once the window is interior, instead of reloading 9 (first) or 3 (subsequent) pixels per output. Sits between the grayscale stage and sobel_core; the window output drives the nine core inputs directly.

Parameters:
PIXEL_WIDTH, 8, bits per pixel
IMG_WIDTH, 64, pixels per row (>=3)
IMG_HEIGHT, 64, rows per frame (>=3)

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous reset, active-high
px_valid_i  input  1  pixel strobe; one pixel accepted per cycle when high
sof_i  input  1  start of frame; qualifies the pixel on the same cycle, ignored when px_valid_i=0
px_i  input  PIXEL_WIDTH  pixel data
window_o  output  9*PIXEL_WIDTH  window; w_k at [k*PIXEL_WIDTH +: PIXEL_WIDTH]
win_valid_o  output  1  window_o valid this cycle
win_first_o  output  1  first window of frame (with win_valid_o)
win_last_o  output  1  last window of frame (with win_valid_o)
win_eol_o  output  1  last window of a row (with win_valid_o)
frame_done_o  output  1  one-cycle pulse after the final frame pixel is accepted
frame_err_o  output  1  one-cycle pulse on sof_i mid-frame

Behaviour:
- Reset (rst_i=1 at posedge): state IDLE, col/row counters 0, all outputs 0, window registers 0. Line buffer contents are not cleared; they are don't-care because of row gating.
- Reset mid-frame: abort immediately. No window or done pulse follows until a new sof_i.
- FSM states:
  - IDLE -> RUN on px_valid_i & sof_i. That pixel is (row 0, col 0). px_valid_i without sof_i in IDLE is dropped.
  - RUN: each accepted pixel advances col. At col=IMG_WIDTH-1, col wraps to 0 and row increments. Accepting (IMG_HEIGHT-1, IMG_WIDTH-1) -> DONE.
  - RUN with px_valid_i & sof_i: assert frame_err_o next cycle. Restart with this pixel as (0,0) and stay in RUN.
  - DONE: frame_done_o=1 for this one cycle, then -> IDLE. A pixel presented in DONE is handled as in IDLE; sof_i in DONE starts a new frame (back-to-back frames allowed).
- Datapath on an accepted pixel p at (r,c):
  - Two line buffers, lb0 = row r-1 and lb1 = row r-2, IMG_WIDTH entries each.
  - Column taps: top=lb1[c], mid=lb0[c], bot=p.
  - Window registers shift one column left. Column 2 becomes {top,mid,bot}.
  - Same cycle: lb1[c]<=lb0[c], lb0[c]<=p.
- Window ordering is row-major from the top-left:
  - w0..w2 = row r-2, cols c-2..c
  - w3..w5 = row r-1, cols c-2..c
  - w6..w8 = row r, cols c-2..c
  - w8 is the newest pixel; the window centre is (r-1,c-1).
- Window emission:
  - win_valid_o=1 the cycle after accepting a pixel with r>=2 and c>=2 (latency 1). Otherwise 0.
  - Interior windows only: (IMG_WIDTH-2)*(IMG_HEIGHT-2) per frame.
  - Stale columns from the previous row are never exposed, because c>=2 gating guarantees two fresh columns.
- Flags (all qualified by win_valid_o):
  - win_first_o when (r,c)=(2,2).
  - win_eol_o when c=IMG_WIDTH-1.
  - win_last_o when (r,c)=(IMG_HEIGHT-1,IMG_WIDTH-1). It coincides with frame_done_o.
- Output hold: window_o holds its last value when win_valid_o=0. All flag outputs are 0 unless stated.
- Gaps: px_valid_i gaps of any length are allowed; state and buffers hold.
- Counters: col is clog2(IMG_WIDTH) bits, row is clog2(IMG_HEIGHT) bits. No arithmetic on pixel data; pure storage.

Test Plan:
(all with PIXEL_WIDTH=8, IMG_WIDTH=5, IMG_HEIGHT=4, pixel value 10*r+c)
- Continuous frame:
  - 6 win_valid_o pulses in total.
  - First pulse is the cycle after pixel (2,2): w0..w8 = 0,1,2,10,11,12,20,21,22, with win_first_o=1.
  - Last pulse: w = 12,13,14,22,23,24,32,33,34, with win_last_o=1 and frame_done_o=1 the same cycle.
- Row boundary:
  - Window after (3,2) = 10,11,12,20,21,22,30,31,32.
  - win_eol_o=1 only after (2,4) and (3,4).
- Random px_valid_i gaps (50% duty): identical window sequence and flags to the continuous run; win_valid_o never asserted in a gap-following idle cycle.
- Pixels before sof_i ignored; sof_i mid-frame at (1,3): frame_err_o pulses once and the new frame produces its first window exactly after new-frame pixel (2,2).
- rst_i asserted after (2,3):
  - All outputs are 0 next cycle.
  - No frame_done_o follows.
  - A subsequent full frame produces exactly 6 correct windows.
- Back-to-back frames: sof_i on the cycle after the last pixel gives 12 windows and 2 frame_done_o pulses, with no frame_err_o.

Source files
------------

// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out bundle for sobel_window_gen.
// The slave side is the window generator; the master side is the upstream driver or the bench.
interface sobel_window_gen_if #(
    parameter int PIXEL_WIDTH = 8
);
    logic                     px_valid_i;
    logic                     sof_i;
    logic [PIXEL_WIDTH-1:0]   px_i;
    logic [9*PIXEL_WIDTH-1:0] window_o;
    logic                     win_valid_o;
    logic                     win_first_o;
    logic                     win_last_o;
    logic                     win_eol_o;
    logic                     frame_done_o;
    logic                     frame_err_o;

    // Strobe-only handshake: a pixel is taken on every posedge with px_valid_i high;
    // there is no ready, so the generator never back-pressures the pixel source.
    modport slave (
        input  px_valid_i, sof_i, px_i,
        output window_o, win_valid_o, win_first_o, win_last_o, win_eol_o,
               frame_done_o, frame_err_o
    );

    modport master (
        output px_valid_i, sof_i, px_i,
        input  window_o, win_valid_o, win_first_o, win_last_o, win_eol_o,
               frame_done_o, frame_err_o
    );
endinterface

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a column shift register,
// emitting one interior window per accepted pixel with one cycle of latency.
module sobel_window_gen #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 64,
    parameter int IMG_HEIGHT  = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    sobel_window_gen_if.slave   pix,
    output logic [1:0]          state_o
);
    localparam int PW    = PIXEL_WIDTH;
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d, cur_col;
    logic [ROW_W-1:0]   row_q, row_d, cur_row;
    logic               start, advance, accept, last_px, emit;
    logic [PW-1:0]      top, mid, bot;
    logic [3*PW-1:0]    new_col, col0_q, col1_q;
    logic [9*PW-1:0]    window_d, window_q;
    logic               valid_q, first_q, last_q, eol_q, err_q;

    logic [PW-1:0]      lb0 [IMG_WIDTH];
    logic [PW-1:0]      lb1 [IMG_WIDTH];

    always_comb begin
        start   = pix.px_valid_i & pix.sof_i;
        advance = pix.px_valid_i & ~pix.sof_i & (state_q == RUN);
        accept  = start | advance;
        // A sof pixel is always (0,0), whatever the counters held before.
        cur_col = start ? '0 : col_q;
        cur_row = start ? '0 : row_q;
        last_px = (cur_col == COL_LAST) && (cur_row == ROW_LAST);
        emit    = accept && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
        top     = lb1[cur_col];
        mid     = lb0[cur_col];
        bot     = pix.px_i;
        new_col = {bot, mid, top};
        // w8 first: bottom row, then middle, then top; oldest column lowest.
        window_d = {bot, col1_q[2*PW +: PW], col0_q[2*PW +: PW],
                    mid, col1_q[PW +: PW],   col0_q[PW +: PW],
                    top, col1_q[0 +: PW],    col0_q[0 +: PW]};

        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = last_px ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
        end

        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (accept && last_px) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            col0_q   <= '0;
            col1_q   <= '0;
            window_q <= '0;
            valid_q  <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            eol_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            if (accept) begin
                col0_q <= col1_q;
                col1_q <= new_col;
            end
            if (emit) window_q <= window_d;
            valid_q <= emit;
            first_q <= emit && (cur_row == ROW_TWO) && (cur_col == COL_TWO);
            eol_q   <= emit && (cur_col == COL_LAST);
            last_q  <= emit && last_px;
            err_q   <= start && (state_q == RUN);
        end
    end

    // Line buffers are never cleared: row gating keeps stale entries out of emitted windows.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            lb1[cur_col] <= lb0[cur_col];
            lb0[cur_col] <= pix.px_i;
        end
    end

    assign pix.window_o     = window_q;
    assign pix.win_valid_o  = valid_q;
    assign pix.win_first_o  = first_q;
    assign pix.win_last_o   = last_q;
    assign pix.win_eol_o    = eol_q;
    assign pix.frame_done_o = (state_q == DONE);
    assign pix.frame_err_o  = err_q;
    assign state_o          = state_q;
endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 5x4 frame with pixel value 10*r+c.
module tb_sobel_window_gen;
    localparam int PW = 8;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int WW = 9 * PW;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] state;

    always #5 clk = ~clk;

    sobel_window_gen_if #(.PIXEL_WIDTH(PW)) ifc ();

    sobel_window_gen #(.PIXEL_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .pix     (ifc.slave),
        .state_o (state)
    );

    int checks = 0;
    int errors = 0;

    logic [WW-1:0] exp_q[$];
    logic [3:0]    exp_flag_q[$];
    logic [WW-1:0] mon_win[$];
    logic [3:0]    mon_flag[$];
    int            done_cnt = 0;
    int            err_cnt  = 0;

    // Monitor: flags packed as {first, last, eol, frame_done}.
    always @(negedge clk) begin
        if (ifc.win_valid_o) begin
            mon_win.push_back(ifc.window_o);
            mon_flag.push_back({ifc.win_first_o, ifc.win_last_o, ifc.win_eol_o, ifc.frame_done_o});
        end
        if (ifc.frame_done_o) done_cnt++;
        if (ifc.frame_err_o) err_cnt++;
    end

    function automatic logic [WW-1:0] win9(input int a, b, c, d, e, f, g, h, i);
        int v[9];
        logic [WW-1:0] w;
        v = '{a, b, c, d, e, f, g, h, i};
        w = '0;
        for (int k = 0; k < 9; k++) w[k*PW +: PW] = PW'(v[k]);
        return w;
    endfunction

    function automatic logic [WW-1:0] exp_window(input int r, input int c);
        logic [WW-1:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) w[k*PW +: PW] = PW'(10 * (r - 2 + k / 3) + (c - 2 + k % 3));
        return w;
    endfunction

    task automatic build_expected(input int nframes);
        exp_q.delete();
        exp_flag_q.delete();
        for (int f = 0; f < nframes; f++)
            for (int r = 2; r < H; r++)
                for (int c = 2; c < W; c++) begin
                    exp_q.push_back(exp_window(r, c));
                    exp_flag_q.push_back({(r == 2 && c == 2), (r == H-1 && c == W-1),
                                          (c == W-1), (r == H-1 && c == W-1)});
                end
    endtask

    task automatic clear_mon();
        mon_win.delete();
        mon_flag.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    // Drive one cycle; returns 1 time unit after the edge that consumed it.
    task automatic send(input logic v, input logic s, input int p);
        ifc.px_valid_i = v;
        ifc.sof_i      = s;
        ifc.px_i       = PW'(p);
        @(posedge clk);
        #1;
        if (!v) begin
            checks++;
            if (ifc.win_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL gap_valid: win_valid_o=%b after idle cycle, required 0", ifc.win_valid_o);
            end
        end
    endtask

    task automatic send_frame(input bit gaps);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                if (gaps) repeat ($urandom_range(0, 2)) send(1'b0, 1'b0, 0);
                send(1'b1, (r == 0 && c == 0), 10 * r + c);
            end
    endtask

    task automatic flush();
        repeat (3) send(1'b0, 1'b0, 0);
    endtask

    task automatic test_reset();
        ifc.px_valid_i = 1'b0;
        ifc.sof_i      = 1'b0;
        ifc.px_i       = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ifc.window_o !== '0) begin errors++; $display("FAIL reset_window: got %h required 0", ifc.window_o); end
        checks++; if (ifc.win_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", ifc.win_valid_o); end
        checks++; if ({ifc.win_first_o, ifc.win_last_o, ifc.win_eol_o} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b required 000", {ifc.win_first_o, ifc.win_last_o, ifc.win_eol_o}); end
        checks++; if ({ifc.frame_done_o, ifc.frame_err_o} !== 2'b00) begin errors++; $display("FAIL reset_done_err: got %b required 00", {ifc.frame_done_o, ifc.frame_err_o}); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d required 0", state); end
        rst = 1'b0;
        send(1'b0, 1'b0, 0);
    endtask

    task automatic test_continuous();
        clear_mon();
        build_expected(1);
        send_frame(1'b0);
        flush();
        checks++; if (mon_win.size() !== 6) begin errors++; $display("FAIL cont_count: got %0d windows required 6", mon_win.size()); end
        for (int i = 0; i < exp_q.size() && i < mon_win.size(); i++) begin
            checks++; if (mon_win[i] !== exp_q[i]) begin errors++; $display("FAIL cont_window[%0d]: got %h required %h", i, mon_win[i], exp_q[i]); end
            checks++; if (mon_flag[i] !== exp_flag_q[i]) begin errors++; $display("FAIL cont_flags[%0d]: got %b required %b", i, mon_flag[i], exp_flag_q[i]); end
        end
        checks++; if (mon_win[0] !== win9(0, 1, 2, 10, 11, 12, 20, 21, 22)) begin errors++; $display("FAIL cont_first_window: got %h", mon_win[0]); end
        checks++; if (mon_win[3] !== win9(10, 11, 12, 20, 21, 22, 30, 31, 32)) begin errors++; $display("FAIL row_boundary_window: got %h", mon_win[3]); end
        checks++; if (mon_win[5] !== win9(12, 13, 14, 22, 23, 24, 32, 33, 34)) begin errors++; $display("FAIL cont_last_window: got %h", mon_win[5]); end
        checks++; if (ifc.window_o !== win9(12, 13, 14, 22, 23, 24, 32, 33, 34)) begin errors++; $display("FAIL hold_window: got %h after frame", ifc.window_o); end
        checks++; if (done_cnt !== 1 || err_cnt !== 0) begin errors++; $display("FAIL cont_done_err: got done=%0d err=%0d required 1/0", done_cnt, err_cnt); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL cont_idle: got state %0d required 0", state); end
    endtask

    task automatic test_gaps();
        clear_mon();
        build_expected(1);
        send_frame(1'b1);
        flush();
        checks++; if (mon_win.size() !== 6) begin errors++; $display("FAIL gaps_count: got %0d windows required 6", mon_win.size()); end
        for (int i = 0; i < exp_q.size() && i < mon_win.size(); i++) begin
            checks++; if (mon_win[i] !== exp_q[i]) begin errors++; $display("FAIL gaps_window[%0d]: got %h required %h", i, mon_win[i], exp_q[i]); end
            checks++; if (mon_flag[i] !== exp_flag_q[i]) begin errors++; $display("FAIL gaps_flags[%0d]: got %b required %b", i, mon_flag[i], exp_flag_q[i]); end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL gaps_done: got %0d required 1", done_cnt); end
    endtask

    task automatic test_sof_mid_frame();
        clear_mon();
        build_expected(1);
        repeat (3) send(1'b1, 1'b0, 7);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL pre_sof_state: got %0d required 0", state); end
        // Old frame runs (0,0)..(1,2); sof lands where (1,3) would be.
        for (int idx = 0; idx < 8; idx++) send(1'b1, (idx == 0), 50 + idx);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                send(1'b1, (r == 0 && c == 0), 10 * r + c);
                if (r < 2 || (r == 2 && c < 2)) begin
                    checks++; if (ifc.win_valid_o !== 1'b0) begin errors++; $display("FAIL sof_early_window: valid at (%0d,%0d)", r, c); end
                end else if (r == 2 && c == 2) begin
                    checks++; if ({ifc.win_valid_o, ifc.win_first_o} !== 2'b11) begin errors++; $display("FAIL sof_first_flags: got %b required 11", {ifc.win_valid_o, ifc.win_first_o}); end
                    checks++; if (ifc.window_o !== win9(0, 1, 2, 10, 11, 12, 20, 21, 22)) begin errors++; $display("FAIL sof_first_window: got %h", ifc.window_o); end
                end
            end
        flush();
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL sof_err_count: got %0d required 1", err_cnt); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL sof_done_count: got %0d required 1", done_cnt); end
        checks++; if (mon_win.size() !== 6) begin errors++; $display("FAIL sof_count: got %0d windows required 6", mon_win.size()); end
        for (int i = 0; i < exp_q.size() && i < mon_win.size(); i++) begin
            checks++; if (mon_win[i] !== exp_q[i]) begin errors++; $display("FAIL sof_window[%0d]: got %h required %h", i, mon_win[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_mon();
        for (int idx = 0; idx < 2 * W + 4; idx++) send(1'b1, (idx == 0), 10 * (idx / W) + idx % W);
        rst = 1'b1;
        send(1'b0, 1'b0, 0);
        checks++; if ({ifc.win_valid_o, ifc.win_first_o, ifc.win_last_o, ifc.win_eol_o, ifc.frame_done_o, ifc.frame_err_o} !== 6'b0)
            begin errors++; $display("FAIL rst_mid_flags: got %b required 000000", {ifc.win_valid_o, ifc.win_first_o, ifc.win_last_o, ifc.win_eol_o, ifc.frame_done_o, ifc.frame_err_o}); end
        checks++; if (ifc.window_o !== '0) begin errors++; $display("FAIL rst_mid_window: got %h required 0", ifc.window_o); end
        rst = 1'b0;
        repeat (2) send(1'b1, 1'b0, 99);
        flush();
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL rst_mid_done: got %0d required 0", done_cnt); end
        checks++; if (mon_win.size() !== 2) begin errors++; $display("FAIL rst_mid_windows: got %0d required 2", mon_win.size()); end
        clear_mon();
        build_expected(1);
        send_frame(1'b0);
        flush();
        checks++; if (mon_win.size() !== 6) begin errors++; $display("FAIL rst_refill_count: got %0d required 6", mon_win.size()); end
        for (int i = 0; i < exp_q.size() && i < mon_win.size(); i++) begin
            checks++; if (mon_win[i] !== exp_q[i]) begin errors++; $display("FAIL rst_refill_window[%0d]: got %h required %h", i, mon_win[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        build_expected(2);
        send_frame(1'b0);
        send_frame(1'b0);
        flush();
        checks++; if (mon_win.size() !== 12) begin errors++; $display("FAIL b2b_count: got %0d windows required 12", mon_win.size()); end
        for (int i = 0; i < exp_q.size() && i < mon_win.size(); i++) begin
            checks++; if (mon_win[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_window[%0d]: got %h required %h", i, mon_win[i], exp_q[i]); end
            checks++; if (mon_flag[i] !== exp_flag_q[i]) begin errors++; $display("FAIL b2b_flags[%0d]: got %b required %b", i, mon_flag[i], exp_flag_q[i]); end
        end
        checks++; if (done_cnt !== 2) begin errors++; $display("FAIL b2b_done: got %0d required 2", done_cnt); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL b2b_err: got %0d required 0", err_cnt); end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_gaps();
        test_sof_mid_frame();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
